uart_tx_buffered: RTL



---
 rtl/uart_tx_buffered_pkg.sv | 12 +
 rtl/uart_tx_buffered_fifo.sv | 47 ++++
 rtl/uart_tx_buffered.sv | 119 +++++++++++
 3 files changed

// File: rtl/uart_tx_buffered_pkg.sv
// Build-time defaults for the buffered UART transmitter: bit timing and store-buffer depth.
package uart_tx_buffered_pkg;

  localparam int unsigned clks_per_bit      = 3;
  localparam int unsigned storebuffer_depth = 4;

  // Occupancy/pointer width: index bits plus one wrap bit.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/uart_tx_buffered_fifo.sv
// Generic synchronous FIFO; wrap-bit pointers distinguish full from empty without a counter.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q;
  logic [PW-1:0]    rptr_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign level_o = wptr_q - rptr_q;
  assign data_o  = mem_q[rptr_q[AW-1:0]];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PW'(1);
      if (do_pop)  rptr_q <= rptr_q + PW'(1);
    end
  end

  // Storage needs no reset; the pointers alone define what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: FIFO-fed serialiser, LSB first, frames back-to-back when queued.
module uart_tx_buffered
  import uart_tx_buffered_pkg::*;
#(
  parameter int CLKS_PER_BIT = clks_per_bit,
  parameter int DEPTH        = storebuffer_depth
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   tx_valid,
  input  logic [7:0]             tx_data,
  output logic                   tx_ready,
  output logic                   tx,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level
);
  localparam int CW = (CLKS_PER_BIT < 1) ? 1 : $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      bitidx_q;
  logic [7:0]      shreg_q;
  logic            tx_q;

  logic            full;
  logic            empty;
  logic            pop;
  logic            cnt_last;
  logic [7:0]      head;

  uart_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clock),
    .rst_i   (reset),
    .push_i  (tx_valid),
    .data_i  (tx_data),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level)
  );

  assign cnt_last = (cnt_q == CNT_LAST);
  // A new byte is taken either from IDLE or on the final stop-bit cycle, so queued frames abut.
  assign pop      = !empty && ((state_q == IDLE) || ((state_q == STOP) && cnt_last));
  assign tx_ready = !full;
  assign busy     = !empty || (state_q != IDLE);
  assign tx       = tx_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bitidx_q <= '0;
      shreg_q  <= '0;
      tx_q     <= 1'b1;
    end else begin
      // Line level follows the state one cycle later, from a flop.
      case (state_q)
        START:   tx_q <= 1'b0;
        DATA:    tx_q <= shreg_q[0];
        default: tx_q <= 1'b1;
      endcase

      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (!empty) begin
            shreg_q <= head;
            state_q <= START;
          end
        end
        START: begin
          if (cnt_last) begin
            cnt_q    <= '0;
            bitidx_q <= '0;
            state_q  <= DATA;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DATA: begin
          if (cnt_last) begin
            cnt_q   <= '0;
            shreg_q <= {1'b0, shreg_q[7:1]};
            if (bitidx_q == 3'd7) begin
              state_q <= STOP;
            end else begin
              bitidx_q <= bitidx_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        STOP: begin
          if (cnt_last) begin
            cnt_q <= '0;
            if (!empty) begin
              shreg_q <= head;
              state_q <= START;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
